rd_bus_arbiter: RTL and testbench
=================================

# rd_bus_arbiter

Shares the single external read-address/read-data bus between several read bridges (conv input fetch, pool input fetch, weight fetch, ...). It arbitrates round-robin and runs one burst at a time. It tags each burst with a requester-specific user ID and routes the returned beats back to the requester that owns the burst. Each bridge sees a private AR/R channel; the bus sees one well-formed master.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..15)
- WIDTH, 32, read data width
- ADDR_W, 28, address width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_arvalid  in  NUM_REQ  per-requester address request
- req_araddr  in  NUM_REQ*ADDR_W  requester i at bits [i*ADDR_W +: ADDR_W]
- req_arlen  in  NUM_REQ*4  burst length minus 1, requester i at [i*4 +: 4]
- req_arready  out  NUM_REQ  one-hot, 1-cycle pulse: request accepted by bus
- req_rvalid  out  NUM_REQ  one-hot beat valid to owning requester
- req_rlast  out  NUM_REQ  one-hot last beat to owning requester
- req_rdata  out  WIDTH  beat data, broadcast to all requesters
- arvalid  out  1  bus address valid
- araddr  out  ADDR_W  bus address
- arlen  out  4  bus burst length minus 1
- aruser_id  out  4  transaction ID = granted index + 1 (0 never issued)
- aruser_ap  out  1  equals arvalid
- arready  in  1  bus address ready
- rvalid  in  1  bus beat valid
- rlast  in  1  bus last beat
- rid  in  4  bus beat ID
- rdata  in  WIDTH  bus beat data
- busy  out  1  high in ADDR or DATA
- grant  out  4  current owner index; valid while busy
- len_err  out  1  1-cycle pulse on burst length mismatch
- stray_beat  out  1  1-cycle pulse on beat with non-matching rid

## Operation
- FSM states:
  - IDLE: if any req_arvalid, choose winner round-robin starting at rr_ptr. Latch grant, araddr_q and arlen_q from the winner, clear beat_cnt, then go to ADDR.
  - ADDR: drive arvalid=1, aruser_ap=1, araddr=araddr_q, arlen=arlen_q, aruser_id=grant+1.
    - On arvalid&&arready: pulse req_arready[grant], go to DATA.
  - DATA: arvalid=0. Each rvalid with rid==grant+1 is a matching beat:
    - assert req_rvalid[grant] and beat_cnt++.
    - req_rlast[grant]=rlast on matching beats.
    - On matching rlast: go to IDLE, rr_ptr=(grant+1) mod NUM_REQ.
- Round-robin: fixed order from rr_ptr upward with wrap. A requester just served has lowest priority next decision.
- Bus address, length and ID are registered at grant. The requester may drop or change req_* after being granted without affecting the bus.
- Requester must keep req_arvalid high until its req_arready pulse. A dropped request in ADDR is still issued. Its data is still routed to it.
- len_err: pulses on matching rlast when beat_cnt (including this beat) != arlen_q+1. FSM still returns to IDLE.
- stray_beat: pulses on rvalid with rid!=grant+1 in DATA, or on any rvalid in IDLE/ADDR. The beat is dropped: no req_rvalid.
- beat_cnt is 5 bits and saturates at 31.
- One burst outstanding at a time; no address pipelining.

## Timing
- Reset (async): state IDLE, rr_ptr=0, grant=0. All outputs 0, including arvalid, araddr, arlen, aruser_id, aruser_ap, req_*, busy, len_err, stray_beat.
- Reset asserted mid-burst aborts immediately. Beats arriving after release are flagged stray_beat.
- req_arvalid rising in cycle N (IDLE) gives arvalid=1 in N+1.
- arready sampled high in cycle M gives req_arready pulse in M (combinational from state and arready). State is DATA in M+1.
- req_rvalid, req_rlast and req_rdata are combinational from rvalid/rlast/rid/rdata: zero latency.
- Matching rlast in cycle L gives IDLE in L+1. Next arvalid is no earlier than L+2.
- len_err and stray_beat are registered: they pulse in the cycle after the offending beat.
- Simultaneous requests in IDLE: exactly one grant; others wait, req_arready low.

## Test plan
- Single request: req 2, addr 0x0000100, arlen 3, arready immediately. Required:
  - arvalid next cycle with aruser_id=3 and req_arready[2] pulse.
  - 4 beats with rid=3 drive req_rvalid=0b0100, with req_rlast on the 4th.
  - Back to IDLE; len_err stays 0.
- Round-robin: all 4 requesters held high. Grant order 0,1,2,3,0; each burst completes with rlast before the next arvalid.
- arready stalled 5 cycles. Required: arvalid, araddr and aruser_id stable; req_arready pulses once, on the accept cycle.
- Stray/error: in DATA for grant 1, inject a beat with rid=4. Required: stray_beat pulse, no req_rvalid.
  - Then arlen=3 with rlast on beat 2: len_err pulse, IDLE.
- Reset mid-burst: rst_n low after beat 2 of 4. Required:
  - All outputs 0 immediately, state IDLE.
  - Remaining beats after release give stray_beat and no req_rvalid.
- Request dropped: requester 0 drops req_arvalid while in ADDR. Required: burst still issued with the latched address, and data routed to requester 0.

Source files
------------

// File: rtl/rd_bus_arbiter_if.sv
// rtl/rd_bus_arbiter_if.sv - requester-side and bus-side read channel bundles
//
// rd_req_if : NUM_REQ private AR/R channels packed side by side.
//   master = the read bridges (drive req_arvalid/req_araddr/req_arlen).
//   slave  = the arbiter (drives req_arready/req_rvalid/req_rlast/req_rdata).
// rd_bus_if : the single shared external read bus.
//   master = the arbiter (drives arvalid/araddr/arlen/aruser_id/aruser_ap).
//   slave  = the memory side (drives arready/rvalid/rlast/rid/rdata).

interface rd_req_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 28,
  parameter int WIDTH   = 32
);
  logic [NUM_REQ-1:0]        req_arvalid;
  logic [NUM_REQ*ADDR_W-1:0] req_araddr;
  logic [NUM_REQ*4-1:0]      req_arlen;
  logic [NUM_REQ-1:0]        req_arready;
  logic [NUM_REQ-1:0]        req_rvalid;
  logic [NUM_REQ-1:0]        req_rlast;
  logic [WIDTH-1:0]          req_rdata;

  modport master (
    output req_arvalid, req_araddr, req_arlen,
    input  req_arready, req_rvalid, req_rlast, req_rdata
  );

  modport slave (
    input  req_arvalid, req_araddr, req_arlen,
    output req_arready, req_rvalid, req_rlast, req_rdata
  );
endinterface

interface rd_bus_if #(
  parameter int ADDR_W = 28,
  parameter int WIDTH  = 32
);
  logic              arvalid;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arlen;
  logic [3:0]        aruser_id;
  logic              aruser_ap;
  logic              arready;
  logic              rvalid;
  logic              rlast;
  logic [3:0]        rid;
  logic [WIDTH-1:0]  rdata;

  modport master (
    output arvalid, araddr, arlen, aruser_id, aruser_ap,
    input  arready, rvalid, rlast, rid, rdata
  );

  modport slave (
    input  arvalid, araddr, arlen, aruser_id, aruser_ap,
    output arready, rvalid, rlast, rid, rdata
  );
endinterface

// File: rtl/rd_bus_arbiter.sv
// rtl/rd_bus_arbiter.sv - round-robin single-burst read bus arbiter
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req          rd_req_if.slave : private AR/R channel per requester
//   bus          rd_bus_if.master: shared read bus, ID = owner index + 1
//   busy         high while a burst is in address or data phase
//   grant        current owner index (valid while busy)
//   len_err      1-cycle pulse after a last beat whose count != arlen+1
//   stray_beat   1-cycle pulse after a beat that no burst owns

module rd_bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 28
) (
  input  logic        clk,
  input  logic        rst_n,
  rd_req_if.slave     req,
  rd_bus_if.master    bus,
  output logic        busy,
  output logic [3:0]  grant,
  output logic        len_err,
  output logic        stray_beat
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        rr_ptr_q, rr_ptr_d;
  logic [3:0]        grant_q, grant_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [3:0]        arlen_q, arlen_d;
  logic [4:0]        beat_cnt_q, beat_cnt_d;
  logic              len_err_q, len_err_d;
  logic              stray_q, stray_d;

  logic              found;
  logic [3:0]        win_idx;
  logic [ADDR_W-1:0] win_addr;
  logic [3:0]        win_len;
  int                idx;

  logic              beat_ok;
  logic [4:0]        cnt_inc;
  logic [NUM_REQ-1:0] grant_oh;

  // Round-robin search: first active requester at or after rr_ptr, wrapping.
  always_comb begin
    found    = 1'b0;
    win_idx  = 4'd0;
    win_addr = '0;
    win_len  = 4'd0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && req.req_arvalid[idx]) begin
        found    = 1'b1;
        win_idx  = 4'(idx);
        win_addr = req.req_araddr[idx*ADDR_W +: ADDR_W];
        win_len  = req.req_arlen[idx*4 +: 4];
      end
    end
  end

  assign grant_oh = NUM_REQ'(1) << grant_q;
  assign beat_ok  = (state_q == ST_DATA) && bus.rvalid && (bus.rid == grant_q + 4'd1);
  assign cnt_inc  = (beat_cnt_q == 5'd31) ? 5'd31 : beat_cnt_q + 5'd1;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    beat_cnt_d = beat_cnt_q;
    len_err_d  = 1'b0;
    // Any beat not owned by the current data phase is dropped and flagged.
    stray_d    = bus.rvalid && !beat_ok;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d    = win_idx;
          araddr_d   = win_addr;
          arlen_d    = win_len;
          beat_cnt_d = 5'd0;
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (bus.arready) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (beat_ok) begin
          beat_cnt_d = cnt_inc;
          if (bus.rlast) begin
            len_err_d = (cnt_inc != ({1'b0, arlen_q} + 5'd1));
            state_d   = ST_IDLE;
            rr_ptr_d  = (grant_q == 4'(NUM_REQ - 1)) ? 4'd0 : grant_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= 4'd0;
      grant_q    <= 4'd0;
      araddr_q   <= '0;
      arlen_q    <= 4'd0;
      beat_cnt_q <= 5'd0;
      len_err_q  <= 1'b0;
      stray_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      beat_cnt_q <= beat_cnt_d;
      len_err_q  <= len_err_d;
      stray_q    <= stray_d;
    end
  end

  // Address channel is a pure decode of registered state; fields read as zero
  // outside the address phase.
  always_comb begin
    bus.arvalid   = (state_q == ST_ADDR);
    bus.aruser_ap = (state_q == ST_ADDR);
    bus.araddr    = (state_q == ST_ADDR) ? araddr_q : '0;
    bus.arlen     = (state_q == ST_ADDR) ? arlen_q : 4'd0;
    bus.aruser_id = (state_q == ST_ADDR) ? grant_q + 4'd1 : 4'd0;
  end

  // Requester side: accept pulse and beat routing are zero-latency.
  always_comb begin
    req.req_arready = ((state_q == ST_ADDR) && bus.arready) ? grant_oh : '0;
    req.req_rvalid  = beat_ok ? grant_oh : '0;
    req.req_rlast   = (beat_ok && bus.rlast) ? grant_oh : '0;
    req.req_rdata   = beat_ok ? bus.rdata : {WIDTH{1'b0}};
  end

  assign busy       = (state_q != ST_IDLE);
  assign grant      = grant_q;
  assign len_err    = len_err_q;
  assign stray_beat = stray_q;

endmodule

// File: tb/tb_rd_bus_arbiter.sv
// tb/tb_rd_bus_arbiter.sv - self-checking bench for rd_bus_arbiter

module tb_rd_bus_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int AW = 28;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rd_req_if #(.NUM_REQ(N), .ADDR_W(AW), .WIDTH(W)) rq();
  rd_bus_if #(.ADDR_W(AW), .WIDTH(W)) bus();

  logic       busy;
  logic [3:0] grant;
  logic       len_err;
  logic       stray_beat;

  rd_bus_arbiter #(.NUM_REQ(N), .WIDTH(W), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (rq),
    .bus        (bus),
    .busy       (busy),
    .grant      (grant),
    .len_err    (len_err),
    .stray_beat (stray_beat)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pending requests and a priority list whose head is the
  // next requester to be considered; a served requester moves to the tail.
  logic [N-1:0]  pend;
  logic [AW-1:0] paddr [N];
  logic [3:0]    plen  [N];
  int            order [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    order = {0, 1, 2, 3};
    pend  = '0;
  endtask

  function automatic int model_pick();
    foreach (order[k]) if (pend[order[k]]) return order[k];
    return 0;
  endfunction

  task automatic model_served(input int w);
    while (order[$] != w) order.push_back(order.pop_front());
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      rq.req_arvalid[i]            = pend[i];
      rq.req_araddr[i*AW +: AW]    = paddr[i];
      rq.req_arlen[i*4 +: 4]       = plen[i];
    end
  endtask

  // One complete burst for requester w, starting at a negedge with requests
  // already driven and the arbiter idle; ends at the negedge after the last beat.
  task automatic run_burst(input int w, input int stall, input bit drop,
                           input int nbeats, input int stray_at, input int srid);
    logic [AW-1:0] ea;
    logic [3:0]    el;
    logic [W-1:0]  d;
    int            waited;
    int            r;
    ea     = paddr[w];
    el     = plen[w];
    waited = 0;
    while (!bus.arvalid && waited < 8) begin
      step();
      waited++;
    end
    chk("ar_latency", waited, 1);
    if (!bus.arvalid) return;
    chk("grant", grant, w);
    chk("aruser_id", bus.aruser_id, w + 1);
    chk("araddr", bus.araddr, ea);
    chk("arlen", bus.arlen, el);
    chk("aruser_ap", bus.aruser_ap, 1);
    chk("busy_addr", busy, 1);

    for (int s = 0; s < stall; s++) begin
      bus.arready = 1'b0;
      if (drop && s == 0) begin
        rq.req_arvalid[w]         = 1'b0;
        rq.req_araddr[w*AW +: AW] = AW'($urandom);
        rq.req_arlen[w*4 +: 4]    = 4'($urandom);
      end
      if (s == 1) begin
        bus.rvalid = 1'b1;
        bus.rid    = 4'(w + 1);
        bus.rdata  = $urandom;
      end
      #1;
      chk("stall_arready", rq.req_arready, 0);
      chk("addr_rvalid", rq.req_rvalid, 0);
      step();
      bus.rvalid = 1'b0;
      chk("addr_stray", stray_beat, s == 1);
      chk("stall_arvalid", bus.arvalid, 1);
      chk("stall_araddr", bus.araddr, ea);
      chk("stall_id", bus.aruser_id, w + 1);
    end

    bus.arready = 1'b1;
    #1;
    chk("accept_arready", rq.req_arready, oh(w));
    step();
    rq.req_arvalid[w] = 1'b0;
    chk("data_arready", rq.req_arready, 0);
    chk("data_arvalid", bus.arvalid, 0);
    bus.arready = 1'b0;

    for (int b = 0; b < nbeats; b++) begin
      if (b == stray_at) begin
        if (srid >= 0) r = srid;
        else begin
          r = $urandom_range(0, 15);
          if (r == w + 1) r = (r + 1) % 16;
        end
        bus.rvalid = 1'b1;
        bus.rid    = 4'(r);
        bus.rlast  = 1'($urandom_range(0, 1));
        bus.rdata  = $urandom;
        #1;
        chk("stray_rvalid", rq.req_rvalid, 0);
        chk("stray_rlast", rq.req_rlast, 0);
        step();
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        chk("stray_pulse", stray_beat, 1);
        chk("stray_busy", busy, 1);
      end
      if ($urandom_range(0, 3) == 0) begin
        step();
        chk("gap_stray", stray_beat, 0);
      end
      d          = $urandom;
      bus.rvalid = 1'b1;
      bus.rid    = 4'(w + 1);
      bus.rdata  = d;
      bus.rlast  = (b == nbeats - 1);
      #1;
      chk("beat_rvalid", rq.req_rvalid, oh(w));
      chk("beat_rlast", rq.req_rlast, (b == nbeats - 1) ? oh(w) : '0);
      chk("beat_rdata", rq.req_rdata, d);
      step();
      bus.rvalid = 1'b0;
      bus.rlast  = 1'b0;
      chk("beat_stray", stray_beat, 0);
      chk("beat_len_err", len_err, (b == nbeats - 1) && (nbeats != int'(el) + 1));
      chk("beat_busy", busy, b != nbeats - 1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int rr_exp [5] = '{0, 1, 2, 3, 0};
  int w, nb, st, sa;
  bit dr;

  initial begin
    rst_n          = 1'b0;
    rq.req_arvalid = '0;
    rq.req_araddr  = '0;
    rq.req_arlen   = '0;
    bus.arready    = 1'b0;
    bus.rvalid     = 1'b0;
    bus.rlast      = 1'b0;
    bus.rid        = 4'd0;
    bus.rdata      = '0;
    for (int i = 0; i < N; i++) begin
      paddr[i] = '0;
      plen[i]  = 4'd0;
    end
    model_reset();
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_araddr", bus.araddr, 0);
    chk("rst_arlen", bus.arlen, 0);
    chk("rst_aruser_id", bus.aruser_id, 0);
    chk("rst_aruser_ap", bus.aruser_ap, 0);
    chk("rst_req_arready", rq.req_arready, 0);
    chk("rst_req_rvalid", rq.req_rvalid, 0);
    chk("rst_req_rlast", rq.req_rlast, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_stray", stray_beat, 0);
    rst_n = 1'b1;
    step();

    // All four held high: fixed grant order, each re-requests after service.
    for (int i = 0; i < N; i++) begin
      pend[i]  = 1'b1;
      paddr[i] = AW'($urandom);
      plen[i]  = 4'($urandom_range(0, 3));
    end
    drive_reqs();
    for (int k = 0; k < 5; k++) begin
      run_burst(rr_exp[k], 0, 1'b0, int'(plen[rr_exp[k]]) + 1, -1, -1);
      model_served(rr_exp[k]);
      paddr[rr_exp[k]] = AW'($urandom);
      if (k == 4) pend = '0;
      drive_reqs();
    end

    // Single request from requester 2, immediate accept.
    pend     = 4'b0100;
    paddr[2] = 28'h0000100;
    plen[2]  = 4'd3;
    drive_reqs();
    run_burst(2, 0, 1'b0, 4, -1, -1);
    model_served(2);
    pend = '0;
    drive_reqs();

    // Address phase stalled for five cycles.
    pend     = 4'b1000;
    paddr[3] = AW'($urandom);
    plen[3]  = 4'd1;
    drive_reqs();
    run_burst(3, 5, 1'b0, 2, -1, -1);
    model_served(3);
    pend = '0;
    drive_reqs();

    // Stray beat with rid 4 during grant 1, then short burst (2 of 4 beats).
    pend     = 4'b0010;
    paddr[1] = AW'($urandom);
    plen[1]  = 4'd3;
    drive_reqs();
    run_burst(1, 0, 1'b0, 2, 0, 4);
    model_served(1);
    pend = '0;
    drive_reqs();

    // Requester 0 drops its request while in address phase.
    pend     = 4'b0001;
    paddr[0] = AW'($urandom);
    plen[0]  = 4'd2;
    drive_reqs();
    run_burst(0, 2, 1'b1, 3, -1, -1);
    model_served(0);
    pend = '0;
    drive_reqs();

    // Reset in the middle of a 4-beat burst for requester 1.
    pend     = 4'b0010;
    paddr[1] = AW'($urandom);
    plen[1]  = 4'd3;
    drive_reqs();
    step();
    chk("mr_arvalid", bus.arvalid, 1);
    bus.arready = 1'b1;
    step();
    bus.arready       = 1'b0;
    rq.req_arvalid[1] = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.rvalid = 1'b1;
      bus.rid    = 4'd2;
      #1;
      chk("mr_beat_rvalid", rq.req_rvalid, 4'b0010);
      step();
    end
    rst_n = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_grant", grant, 0);
    chk("mr_arvalid0", bus.arvalid, 0);
    chk("mr_rvalid0", rq.req_rvalid, 0);
    chk("mr_len_err", len_err, 0);
    chk("mr_stray0", stray_beat, 0);
    step();
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("mr_post_rvalid", rq.req_rvalid, 0);
    step();
    chk("mr_post_stray", stray_beat, 1);
    bus.rlast = 1'b1;
    #1;
    chk("mr_post_rlast", rq.req_rlast, 0);
    step();
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    chk("mr_post_stray2", stray_beat, 1);
    chk("mr_post_len_err", len_err, 0);
    chk("mr_post_busy", busy, 0);
    step();

    // Randomized traffic against the model.
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]  = 1'b1;
          paddr[i] = AW'($urandom);
          plen[i]  = 4'($urandom);
        end
      end
      if (pend == '0) begin
        w        = $urandom_range(0, N - 1);
        pend[w]  = 1'b1;
        paddr[w] = AW'($urandom);
        plen[w]  = 4'($urandom);
      end
      drive_reqs();
      w  = model_pick();
      st = $urandom_range(0, 3);
      dr = (st > 0) && ($urandom_range(0, 3) == 0);
      nb = int'(plen[w]) + 1;
      if ($urandom_range(0, 4) == 0) nb = $urandom_range(1, 20);
      sa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb - 1) : -1;
      run_burst(w, st, dr, nb, sa, -1);
      pend[w] = 1'b0;
      model_served(w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
